// File: rtl/cache_traffic_gen_pkg.sv
// Shared definitions for the CPU-side cache traffic generator: FSM state
// encoding, default LFSR feedback taps and default seed.
package cache_tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1 as a mask over state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/cache_traffic_gen_if.sv
// CPU-port bundle between the traffic generator (master) and the L1 cache (slave).
interface cache_traffic_gen_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data_in;
  logic                  cpu_read;
  logic                  cpu_write;
  logic                  cpu_ready;
  logic                  cpu_hit;

  modport master (
    output cpu_addr, cpu_data_in, cpu_read, cpu_write,
    input  cpu_ready, cpu_hit
  );

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_read, cpu_write,
    output cpu_ready, cpu_hit
  );
endinterface

// File: rtl/cache_traffic_gen_lfsr_n.sv
// Generic Fibonacci LFSR: shifts left, XOR of tapped bits feeds bit 0.
module lfsr_n
  import cache_tb_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(LFSR_TAPS),
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load)
      value_d = load_val;
    else if (advance)
      value_d = {value_q[WIDTH-2:0], ^(value_q & TAPS)};
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) value_q <= RST_VAL;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/cache_traffic_gen.sv
// LFSR-driven mixed read/write request generator for the L1 CPU port, with
// inter-request gaps, a response timeout and on-chip latency/hit statistics.
module cache_traffic_gen
  import cache_tb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(DEFAULT_SEED),
  parameter logic [LFSR_WIDTH-1:0] TAPS       = LFSR_WIDTH'(LFSR_TAPS),
  parameter int                    CNT_WIDTH  = 16,
  parameter int                    TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LFSR_WIDTH-1:0] seed_value,
  input  logic [CNT_WIDTH-1:0]  num_req,
  input  logic [4:0]            wr_ratio,
  input  logic [ADDR_WIDTH-1:0] addr_mask,
  input  logic [3:0]            gap,
  cache_traffic_gen_if.master   cpu,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  req_count,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  lat_total,
  output logic [CNT_WIDTH-1:0]  lat_max
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_ISSUE = S_ISSUE;
  localparam logic [2:0] ST_WAIT  = S_WAIT;
  localparam logic [2:0] ST_GAP   = S_GAP;
  localparam logic [2:0] ST_DONE  = S_DONE;

  localparam int                   LAT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [2:0]            state_q, state_d;
  logic                  ready_q;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [4:0]            ratio_q, ratio_d;
  logic [ADDR_WIDTH-1:0] mask_q, mask_d;
  logic [3:0]            gap_cfg_q, gap_cfg_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  is_wr_q, is_wr_d;
  logic                  error_q, error_d;
  logic [CNT_WIDTH-1:0]  req_q, req_d, hit_q, hit_d, wr_q, wr_d;
  logic [CNT_WIDTH-1:0]  lat_tot_q, lat_tot_d, lat_max_q, lat_max_d;

  logic [LFSR_WIDTH-1:0] lfsr_val;
  logic                  start_ok, in_issue, is_wr_now, complete;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [DATA_WIDTH-1:0] issue_data;
  logic [CNT_WIDTH-1:0]  latency, req_next;
  logic [CNT_WIDTH:0]    lat_sum;

  assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign in_issue   = (state_q == ST_ISSUE);
  assign issue_addr = lfsr_val[ADDR_WIDTH-1:0] & mask_q;
  assign issue_data = lfsr_val[LFSR_WIDTH-1 -: DATA_WIDTH];
  // Top nibble is always < 16, so ratios above 16 behave like 16
  assign is_wr_now  = {1'b0, lfsr_val[LFSR_WIDTH-1 -: 4]} < ratio_q;
  // Only a rising edge of ready completes, so a stale ready level cannot
  assign complete   = (state_q == ST_WAIT) && cpu.cpu_ready && !ready_q;
  assign latency    = CNT_WIDTH'(lat_q) + CNT_ONE;
  assign lat_sum    = {1'b0, lat_tot_q} + {1'b0, latency};
  assign req_next   = req_q + CNT_ONE;

  lfsr_n #(
    .WIDTH   (LFSR_WIDTH),
    .TAPS    (TAPS),
    .RST_VAL (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .load_val ((seed_value == '0) ? SEED : seed_value),
    .advance  (in_issue),
    .value    (lfsr_val)
  );

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    gap_cnt_d = gap_cnt_q;
    num_d     = num_q;
    ratio_d   = ratio_q;
    mask_d    = mask_q;
    gap_cfg_d = gap_cfg_q;
    addr_d    = addr_q;
    data_d    = data_q;
    is_wr_d   = is_wr_q;
    error_d   = error_q;
    req_d     = req_q;
    hit_d     = hit_q;
    wr_d      = wr_q;
    lat_tot_d = lat_tot_q;
    lat_max_d = lat_max_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_d     = num_req;
          ratio_d   = wr_ratio;
          mask_d    = addr_mask;
          gap_cfg_d = gap;
          error_d   = 1'b0;
          req_d     = '0;
          hit_d     = '0;
          wr_d      = '0;
          lat_tot_d = '0;
          lat_max_d = '0;
          state_d   = (num_req == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        addr_d  = issue_addr;
        data_d  = issue_data;
        is_wr_d = is_wr_now;
        lat_d   = LAT_W'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (complete) begin
          req_d     = req_next;
          hit_d     = cpu.cpu_hit ? hit_q + CNT_ONE : hit_q;
          wr_d      = is_wr_q ? wr_q + CNT_ONE : wr_q;
          lat_tot_d = lat_sum[CNT_WIDTH] ? '1 : lat_sum[CNT_WIDTH-1:0];
          lat_max_d = (latency > lat_max_q) ? latency : lat_max_q;
          if (req_next == num_q) begin
            state_d = ST_DONE;
          end else if (gap_cfg_q != 4'd0) begin
            gap_cnt_d = gap_cfg_q;
            state_d   = ST_GAP;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (lat_q >= LAT_W'(TIMEOUT)) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= 4'd1) state_d = ST_ISSUE;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      lat_q     <= '0;
      gap_cnt_q <= '0;
      num_q     <= '0;
      ratio_q   <= '0;
      mask_q    <= '0;
      gap_cfg_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      is_wr_q   <= 1'b0;
      error_q   <= 1'b0;
      req_q     <= '0;
      hit_q     <= '0;
      wr_q      <= '0;
      lat_tot_q <= '0;
      lat_max_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= cpu.cpu_ready;
      lat_q     <= lat_d;
      gap_cnt_q <= gap_cnt_d;
      num_q     <= num_d;
      ratio_q   <= ratio_d;
      mask_q    <= mask_d;
      gap_cfg_q <= gap_cfg_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      is_wr_q   <= is_wr_d;
      error_q   <= error_d;
      req_q     <= req_d;
      hit_q     <= hit_d;
      wr_q      <= wr_d;
      lat_tot_q <= lat_tot_d;
      lat_max_q <= lat_max_d;
    end
  end

  // Address/data come straight from the LFSR in ISSUE, then held until the next issue
  assign cpu.cpu_addr    = in_issue ? issue_addr : addr_q;
  assign cpu.cpu_data_in = in_issue ? issue_data : data_q;
  assign cpu.cpu_read    = in_issue && !is_wr_now;
  assign cpu.cpu_write   = in_issue && is_wr_now;

  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_GAP);
  assign done      = (state_q == ST_DONE);
  assign error     = error_q;
  assign req_count = req_q;
  assign hit_count = hit_q;
  assign wr_count  = wr_q;
  assign lat_total = lat_tot_q;
  assign lat_max   = lat_max_q;

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Scoreboard bench for cache_traffic_gen: expected requests queued per run, a
// monitor checks every issue, a cache responder drives ready/hit.
module tb_cache_traffic_gen;
  import cache_tb_pkg::*;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
    bit          wr;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] seed_value;
  logic [15:0] num_req;
  logic [4:0]  wr_ratio;
  logic [10:0] addr_mask;
  logic [3:0]  gap;
  logic        busy, done, error;
  logic [15:0] req_count, hit_count, wr_count, lat_total, lat_max;

  cache_traffic_gen_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) bus ();

  cache_traffic_gen #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed_value (seed_value),
    .num_req    (num_req),
    .wr_ratio   (wr_ratio),
    .addr_mask  (addr_mask),
    .gap        (gap),
    .cpu        (bus.master),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .req_count  (req_count),
    .hit_count  (hit_count),
    .wr_count   (wr_count),
    .lat_total  (lat_total),
    .lat_max    (lat_max)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  req_t exp_q[$];
  int   lat_list[$];
  int   hit_list[$];
  int   exp_n, exp_wr, exp_bound;
  bit   exp_to;
  bit   stuck = 0;
  int   fixed_d = 0;
  int   comp_cyc = 0;
  int   n_issue = 0;
  int   last_issue_cyc = 0;
  int   done_cyc = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Cache model: drops ready at issue, raises it again after d cycles (latency d+1)
  initial begin
    int cd, cur_d, h;
    cd = 0; cur_d = 0;
    bus.cpu_ready = 1'b0;
    bus.cpu_hit   = 1'b0;
    forever begin
      @(negedge clk);
      if (stuck) begin
        bus.cpu_ready = 1'b1;
        cd = 0;
      end else if (rst_n || !busy) begin
        cd = 0;
      end else if (bus.cpu_read || bus.cpu_write) begin
        bus.cpu_ready = 1'b0;
        cur_d = (fixed_d != 0) ? fixed_d : int'($urandom_range(1, 6));
        cd = cur_d;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          h = int'($urandom_range(0, 1));
          bus.cpu_ready = 1'b1;
          bus.cpu_hit   = h[0];
          lat_list.push_back(cur_d + 1);
          hit_list.push_back(h);
          comp_cyc = cyc;
        end
      end
    end
  end

  // Monitor: every issue pops one expected request; request must hold while busy
  initial begin
    req_t e;
    bit prev_busy;
    logic [10:0] hold_addr;
    logic [7:0]  hold_data;
    prev_busy = 1'b0; hold_addr = '0; hold_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (bus.cpu_read || bus.cpu_write) begin
          n_issue++;
          last_issue_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_issue", 64'(bus.cpu_addr), 64'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("issue_addr", 64'(bus.cpu_addr), 64'(e.addr));
            chk("issue_data", 64'(bus.cpu_data_in), 64'(e.data));
            chk("issue_rw", {62'd0, bus.cpu_write, bus.cpu_read}, {62'd0, e.wr, !e.wr});
          end
          if (prev_busy) chk("issue_gap", 64'(cyc - comp_cyc), 64'(gap) + 64'd1);
          hold_addr = bus.cpu_addr;
          hold_data = bus.cpu_data_in;
        end else if (busy) begin
          chk("req_hold", {45'd0, bus.cpu_addr, bus.cpu_data_in}, {45'd0, hold_addr, hold_data});
        end
      end
      prev_busy = busy;
    end
  end

  task automatic start_run(input logic [15:0] seed, input int n, input logic [4:0] ratio,
                           input logic [10:0] mask, input logic [3:0] g, input bit to);
    logic [15:0] s;
    req_t r;
    int cnt, lim;
    s = (seed == 16'd0) ? 16'hACE1 : seed;
    lim = (ratio > 5'd16) ? 16 : int'(ratio);
    cnt = to ? 1 : n;
    exp_to = to;
    exp_n  = to ? 0 : n;
    exp_wr = 0;
    exp_bound = 60 + cnt * (12 + int'(g));
    lat_list.delete();
    hit_list.delete();
    for (int i = 0; i < cnt; i++) begin
      r.addr = s[10:0] & mask;
      r.data = s[15:8];
      r.wr   = int'(s[15:12]) < lim;
      if (!to && r.wr) exp_wr++;
      exp_q.push_back(r);
      s = lfsr_step(s);
    end
    seed_value = seed;
    num_req    = 16'(n);
    wr_ratio   = ratio;
    addr_mask  = mask;
    gap        = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input string nm);
    longint sum, mx, hits;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < exp_bound; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    done_cyc = cyc;
    if (!seen) chk({nm, "_done_timeout"}, 64'd0, 64'd1);
    sum = 0; mx = 0; hits = 0;
    foreach (lat_list[i]) begin
      sum += lat_list[i];
      if (lat_list[i] > mx) mx = lat_list[i];
    end
    foreach (hit_list[i]) hits += hit_list[i];
    if (sum > 65535) sum = 65535;
    if (exp_to) begin sum = 0; mx = 0; hits = 0; end
    chk({nm, "_req_count"}, 64'(req_count), 64'(exp_n));
    chk({nm, "_hit_count"}, 64'(hit_count), 64'(hits));
    chk({nm, "_wr_count"},  64'(wr_count),  64'(exp_wr));
    chk({nm, "_lat_total"}, 64'(lat_total), 64'(sum));
    chk({nm, "_lat_max"},   64'(lat_max),   64'(mx));
    chk({nm, "_flags"}, {61'd0, busy, done, error}, {61'd0, 1'b0, 1'b1, exp_to});
    chk({nm, "_leftover"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {61'd0, busy, done, error}, 64'd0);
    chk({nm, "_stats"}, {req_count, hit_count, wr_count, lat_total}, 64'd0);
    chk({nm, "_bus"}, {41'd0, lat_max[3:0], bus.cpu_addr, bus.cpu_data_in, bus.cpu_read, bus.cpu_write},
        64'd0);
  endtask

  initial begin
    int base;
    rst_n = 1'b1; start = 1'b0; seed_value = '0; num_req = '0;
    wr_ratio = '0; addr_mask = '0; gap = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b0;
    @(negedge clk);

    // Single read, fixed latency of 4
    fixed_d = 3;
    start_run(16'h0123, 1, 5'd0, 11'h7FF, 4'd0, 1'b0);
    finish_run("single");
    chk("single_lat", {lat_max, lat_total}, {16'd4, 16'd4});
    fixed_d = 0;

    start_run(16'hBEEF, 8, 5'd16, 11'h7FF, 4'd1, 1'b0);
    finish_run("allwr");
    chk("allwr_wr_count", 64'(wr_count), 64'd8);

    start_run(16'h0000, 100, 5'd5, 11'h00F, 4'd0, 1'b0);
    finish_run("mask");

    for (int r = 0; r < 4; r++) begin
      start_run(16'($urandom), int'($urandom_range(1, 20)), 5'($urandom_range(0, 20)),
                11'($urandom), 4'($urandom_range(0, 4)), 1'b0);
      finish_run("rand");
    end

    // Gap of 3 with an extra start pulse mid-run that must be ignored
    start_run(16'h1357, 2, 5'd8, 11'h7FF, 4'd3, 1'b0);
    @(negedge clk);
    seed_value = 16'hFFFF;
    num_req    = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_run("gap3");

    base = n_issue;
    start_run(16'h2222, 0, 5'd8, 11'h7FF, 4'd0, 1'b0);
    chk("zero_done_next", 64'(done), 64'd1);
    finish_run("zero");
    chk("zero_no_issue", 64'(n_issue - base), 64'd0);

    stuck = 1'b1;
    repeat (2) @(negedge clk);
    start_run(16'h4321, 3, 5'd0, 11'h7FF, 4'd0, 1'b1);
    finish_run("timeout");
    chk("timeout_cycles", 64'(done_cyc - last_issue_cyc), 64'd17);
    stuck = 1'b0;
    @(negedge clk);

    // Reset during WAIT, then the same seed must replay the same sequence
    fixed_d = 5;
    base = n_issue;
    start_run(16'h5A5A, 6, 5'd8, 11'h3FF, 4'd2, 1'b0);
    for (int i = 0; i < 400 && n_issue < base + 2; i++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_zero("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    fixed_d = 0;
    start_run(16'h5A5A, 6, 5'd8, 11'h3FF, 4'd2, 1'b0);
    finish_run("replay");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_traffic_gen.md
Name: cache_traffic_gen

Overview:
Synthesizable, parametrised CPU-side traffic generator for the L1/L2/memory hierarchy. It replaces fixed random-read stimulus with LFSR-driven mixed read/write requests, a programmable address window, inter-request gaps, a response timeout, and on-chip statistics. It sits in place of the CPU and drives the L1_cache CPU port, so the same stimulus can run in simulation and on FPGA.

Parameters:
ADDR_WIDTH, 11, CPU address width; must be <= LFSR_WIDTH.
DATA_WIDTH, 8, CPU data width; must be <= LFSR_WIDTH.
LFSR_WIDTH, 16, LFSR state width; taps x^16+x^14+x^13+x^11+1, Fibonacci form, shift left, feedback into bit 0.
SEED, 16'hACE1, seed used when seed_value==0.
CNT_WIDTH, 16, width of num_req and all statistic counters.
TIMEOUT, 1024, maximum WAIT cycles before an error abort.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; starts a run when IDLE or DONE, ignored otherwise
seed_value  in  LFSR_WIDTH  seed loaded on start; 0 selects SEED
num_req  in  CNT_WIDTH  number of requests in the run; 0 goes straight to DONE
wr_ratio  in  5  writes per 16 requests, 0..16; values above 16 act as 16
addr_mask  in  ADDR_WIDTH  ANDed onto the generated address
gap  in  4  idle cycles between a completion and the next issue
cpu_addr  out  ADDR_WIDTH  request address
cpu_data_in  out  DATA_WIDTH  write data
cpu_read  out  1  read request pulse
cpu_write  out  1  write request pulse
cpu_ready  in  1  cache response ready
cpu_hit  in  1  L1 hit indication; sampled with the completion
busy  out  1  high in ISSUE/WAIT/GAP
done  out  1  high in DONE until the next start
error  out  1  sticky timeout flag, cleared on start
req_count  out  CNT_WIDTH  completed requests
hit_count  out  CNT_WIDTH  completions where cpu_hit was 1
wr_count  out  CNT_WIDTH  completed writes
lat_total  out  CNT_WIDTH  sum of latencies, saturating
lat_max  out  CNT_WIDTH  largest single latency

Behaviour:
- Reset: all outputs 0, FSM in IDLE, LFSR = SEED, ready_q = 0.
- States: IDLE, ISSUE, WAIT, GAP, DONE.
- On start: load the LFSR with the selected seed, clear counters and error, latch num_req, wr_ratio, addr_mask and gap. Go to ISSUE, or to DONE if num_req==0.
- ISSUE (exactly 1 cycle):
  - cpu_addr = lfsr[ADDR_WIDTH-1:0] & addr_mask.
  - cpu_data_in = lfsr[LFSR_WIDTH-1 -: DATA_WIDTH].
  - is_wr = (lfsr[LFSR_WIDTH-1 -: 4] < wr_ratio); cpu_write = is_wr, cpu_read = !is_wr. Exactly one of the two is high.
  - The LFSR advances once, at the end of ISSUE. Go to WAIT with the latency counter = 1.
- Request hold: cpu_addr and cpu_data_in stay stable from ISSUE through the completion cycle. cpu_read/cpu_write are low outside ISSUE.
- WAIT:
  - ready_q is a registered copy of cpu_ready. Completion = cpu_ready & !ready_q, i.e. a rising edge. This makes a ready level left over from the previous request unable to complete the next one.
  - Latency counter increments every WAIT cycle. Latency = cycles from ISSUE to completion, inclusive of the completion cycle.
  - On completion:
    - req_count++; hit_count++ if cpu_hit; wr_count++ if is_wr.
    - lat_total += latency, saturating at all-ones.
    - lat_max = max(lat_max, latency).
    - Next state: DONE if req_count+1 == num_req; GAP if gap != 0; otherwise ISSUE.
  - Timeout: if the latency counter reaches TIMEOUT without a completion, set error and go to DONE. The request is not counted.
- GAP: count gap cycles, then go to ISSUE.
- DONE: done = 1; statistics hold.
- start while busy is ignored.
- Reset mid-run aborts immediately and produces the reset values above. Reset has priority over start.
- All counters are CNT_WIDTH wide. lat_total saturates; the other counters cannot exceed num_req.

Decomposition:
- Shared package cache_tb_pkg: state enum (IDLE, ISSUE, WAIT, GAP, DONE), the LFSR tap constant, and the default SEED.
- One sub-module, lfsr_n. Parameters: WIDTH, TAPS. Ports: load, load_val, advance, value. It generalises the existing 4-bit lfsr.

Test Plan:
- seed_value=0x0123, num_req=1, wr_ratio=0, addr_mask=0x7FF, gap=0; cache raises cpu_ready 3 cycles after issue -> cpu_addr=0x123 and cpu_read high for exactly 1 cycle, cpu_write=0, req_count=1, lat_max=lat_total=4, done=1.
- wr_ratio=16, num_req=8 -> 8 cpu_write pulses, 0 cpu_read pulses, wr_count=8; cpu_data_in equals the LFSR top byte at each ISSUE.
- addr_mask=0x00F, num_req=100, full L1/L2/memory hierarchy connected -> every cpu_addr <= 0x00F; hit_count >= 99 (the 16-byte range fits one L1 block); req_count=100.
- cpu_ready held at 1 constantly, TIMEOUT=16 -> no rising edge occurs; error=1 after 16 WAIT cycles, req_count=0, done=1.
- gap=3, num_req=2 -> exactly 3 idle cycles between the first completion and the second ISSUE; a start pulse during the run is ignored; num_req=0 -> done on the cycle after start with no request issued.
- rst_n asserted during WAIT -> all outputs 0 immediately. A later start with the same seed reproduces the same address sequence.
